// File: rtl/msp430_irq_agg.sv
// Interrupt aggregator for the MSP430 peripheral bus: per-source enable, edge/level
// mode, polarity, pending flags and vector read. Define IRQ_AGG_SYNC_EN for async pins.
module msp430_irq_agg #(
  parameter int          NSRC      = 8,
  parameter logic [13:0] BASE_ADDR = 14'h0048
) (
  input  logic            mclk,
  input  logic            puc_rst,
  input  logic [13:0]     per_addr,
  input  logic [15:0]     per_din,
  input  logic            per_en,
  input  logic [1:0]      per_we,
  output logic [15:0]     per_dout,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] irq_acc,
  output logic [NSRC-1:0] irq_out,
  output logic            irq_any
);

  localparam logic [2:0] OFF_IE   = 3'd0;
  localparam logic [2:0] OFF_IFG  = 3'd1;
  localparam logic [2:0] OFF_EDGE = 3'd2;
  localparam logic [2:0] OFF_POL  = 3'd3;
  localparam logic [2:0] OFF_VEC  = 3'd4;
  localparam logic [2:0] OFF_SET  = 3'd5;

  logic            sel;
  logic            rd_en;
  logic            wr_en;
  logic [2:0]      off;
  logic [15:0]     wmask16;
  logic [15:0]     wdat16;
  logic [NSRC-1:0] wdat;

  logic [NSRC-1:0] ie_q,   ie_d;
  logic [NSRC-1:0] ifg_q,  ifg_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [NSRC-1:0] pol_q,  pol_d;
  logic [NSRC-1:0] s_q,    s_d;
  logic [NSRC-1:0] irq_q,  irq_d;

  logic [NSRC-1:0] src_raw;
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] vec_oh;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] set_w;
  logic [15:0]     vec_val;
  logic            vec_found;
  logic [15:0]     rdat;
  logic            unused_din;

  assign sel     = per_en & (per_addr[13:3] == BASE_ADDR[13:3]);
  assign off     = per_addr[2:0];
  assign rd_en   = sel & (per_we == 2'b00);
  assign wr_en   = sel & (per_we != 2'b00);
  assign wmask16 = {{8{per_we[1]}}, {8{per_we[0]}}};
  assign wdat16  = per_din & wmask16;
  assign wdat    = wdat16[NSRC-1:0];

  // Upper data bits beyond NSRC have no storage behind them.
  assign unused_din = ^wdat16;

`ifdef IRQ_AGG_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign src_raw = sync2_q;
`else
  assign src_raw = irq_src;
`endif

  assign s    = src_raw ^ pol_q;
  assign rise = s & ~s_q;
  // Delay line is loaded with the post-write polarity so a POL change is never seen as an edge.
  assign s_d  = src_raw ^ pol_d;
  assign pend = ie_q & ifg_q;

  always_comb begin
    ie_d   = ie_q;
    edge_d = edge_q;
    pol_d  = pol_q;
    if (wr_en && off == OFF_IE)   ie_d   = (ie_q   & ~wmask16[NSRC-1:0]) | wdat;
    if (wr_en && off == OFF_EDGE) edge_d = (edge_q & ~wmask16[NSRC-1:0]) | wdat;
    if (wr_en && off == OFF_POL)  pol_d  = (pol_q  & ~wmask16[NSRC-1:0]) | wdat;
  end

  // Lowest-numbered enabled pending source owns the vector.
  always_comb begin
    vec_val   = '0;
    vec_oh    = '0;
    vec_found = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (pend[i] && !vec_found) begin
        vec_found = 1'b1;
        vec_val   = 16'(2 * (i + 1));
        vec_oh[i] = 1'b1;
      end
    end
  end

  assign set_w = (wr_en && off == OFF_SET) ? wdat : '0;
  assign clr   = ((wr_en && off == OFF_IFG) ? wdat : '0)
               | irq_acc
               | ((rd_en && off == OFF_VEC) ? vec_oh : '0);

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_ifg
      assign ifg_d[gi] = edge_q[gi] ? (rise[gi] | set_w[gi] | (ifg_q[gi] & ~clr[gi]))
                                    : s[gi];
    end
  endgenerate

  assign irq_d = ie_q & ifg_q;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      ie_q   <= '0;
      ifg_q  <= '0;
      edge_q <= '0;
      pol_q  <= '0;
      s_q    <= '0;
      irq_q  <= '0;
    end else begin
      ie_q   <= ie_d;
      ifg_q  <= ifg_d;
      edge_q <= edge_d;
      pol_q  <= pol_d;
      s_q    <= s_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rdat = '0;
    case (off)
      OFF_IE:   rdat = 16'(ie_q);
      OFF_IFG:  rdat = 16'(ifg_q);
      OFF_EDGE: rdat = 16'(edge_q);
      OFF_POL:  rdat = 16'(pol_q);
      OFF_VEC:  rdat = vec_val;
      default:  rdat = '0;
    endcase
    per_dout = rd_en ? rdat : 16'h0000;
  end

  assign irq_out = irq_q;
  assign irq_any = |irq_q;

endmodule

// File: tb/tb_msp430_irq_agg.sv
// Directed bench for msp430_irq_agg (NSRC=16): register table plus edge, level,
// collision, polarity and reset sequences; latency follows IRQ_AGG_SYNC_EN.
module tb_msp430_irq_agg;

  localparam logic [13:0] BASE = 14'h0048;
`ifdef IRQ_AGG_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        mclk;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [15:0] irq_src;
  logic [15:0] irq_acc;
  logic [15:0] irq_out;
  logic        irq_any;

  msp430_irq_agg #(.NSRC(16), .BASE_ADDR(BASE)) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .irq_src  (irq_src),
    .irq_acc  (irq_acc),
    .irq_out  (irq_out),
    .irq_any  (irq_any)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [13:0] addr;
    logic [1:0]  we;
    logic [15:0] din;
    logic        chk_d;
    logic [15:0] exp_d;
    logic        chk_i;
    logic [15:0] exp_i;
  } vec_t;

  localparam int NV = 39;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] s_dout;
  logic [15:0] s_irq;
  logic        s_any;

  function automatic vec_t mk(input logic rst, input logic en, input logic [13:0] addr,
                              input logic [1:0] we, input logic [15:0] din,
                              input logic chk_d, input logic [15:0] exp_d,
                              input logic chk_i, input logic [15:0] exp_i);
    vec_t v;
    v.rst = rst; v.en = en; v.addr = addr; v.we = we; v.din = din;
    v.chk_d = chk_d; v.exp_d = exp_d; v.chk_i = chk_i; v.exp_i = exp_i;
    return v;
  endfunction

  function automatic vec_t rv(input logic [2:0] off, input logic [15:0] exp_d,
                              input logic [15:0] exp_i);
    return mk(1'b0, 1'b1, BASE + 14'(off), 2'b00, 16'h0, 1'b1, exp_d, 1'b1, exp_i);
  endfunction

  function automatic vec_t wv(input logic [2:0] off, input logic [1:0] we,
                              input logic [15:0] din, input logic [15:0] exp_i);
    return mk(1'b0, 1'b1, BASE + 14'(off), we, din, 1'b0, 16'h0, 1'b1, exp_i);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, sample on the falling edge.
  task automatic cyc(input logic rst, input logic en, input logic [13:0] addr,
                     input logic [1:0] we, input logic [15:0] din);
    puc_rst  = rst;
    per_en   = en;
    per_addr = addr;
    per_we   = we;
    per_din  = din;
    @(negedge mclk);
    s_dout = per_dout;
    s_irq  = irq_out;
    s_any  = irq_any;
    @(posedge mclk);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] din);
    cyc(1'b0, 1'b1, BASE + 14'(off), 2'b11, din);
  endtask

  task automatic rd(input logic [2:0] off);
    cyc(1'b0, 1'b1, BASE + 14'(off), 2'b00, 16'h0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 14'h0, 2'b00, 16'h0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 14'h0, 2'b00, 16'h0);
    cyc(1'b1, 1'b0, 14'h0, 2'b00, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    puc_rst = 1'b1; per_en = 1'b0; per_addr = '0; per_we = '0; per_din = '0;
    irq_src = '0; irq_acc = '0;

    // Reset, register access, byte lanes, VEC priority and clear behaviour.
    tbl[0]  = mk(1'b1, 1'b0, 14'h0, 2'b00, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    tbl[1]  = mk(1'b1, 1'b0, 14'h0, 2'b00, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0);
    tbl[2]  = rv(3'd0, 16'h0000, 16'h0);
    tbl[3]  = rv(3'd1, 16'h0000, 16'h0);
    tbl[4]  = rv(3'd2, 16'h0000, 16'h0);
    tbl[5]  = rv(3'd3, 16'h0000, 16'h0);
    tbl[6]  = rv(3'd4, 16'h0000, 16'h0);
    tbl[7]  = rv(3'd5, 16'h0000, 16'h0);
    tbl[8]  = rv(3'd6, 16'h0000, 16'h0);
    tbl[9]  = rv(3'd7, 16'h0000, 16'h0);
    tbl[10] = wv(3'd0, 2'b11, 16'h1234, 16'h0);
    tbl[11] = rv(3'd0, 16'h1234, 16'h0);
    tbl[12] = wv(3'd0, 2'b10, 16'hFF00, 16'h0);
    tbl[13] = rv(3'd0, 16'hFF34, 16'h0);
    tbl[14] = wv(3'd0, 2'b01, 16'h00AB, 16'h0);
    tbl[15] = rv(3'd0, 16'hFFAB, 16'h0);
    tbl[16] = wv(3'd2, 2'b11, 16'hFFFF, 16'h0);
    tbl[17] = rv(3'd2, 16'hFFFF, 16'h0);
    tbl[18] = wv(3'd6, 2'b11, 16'hFFFF, 16'h0);
    tbl[19] = rv(3'd6, 16'h0000, 16'h0);
    tbl[20] = mk(1'b0, 1'b1, 14'h0050, 2'b00, 16'h0, 1'b1, 16'h0000, 1'b1, 16'h0);
    tbl[21] = mk(1'b0, 1'b0, BASE, 2'b00, 16'h0, 1'b1, 16'h0000, 1'b1, 16'h0);
    tbl[22] = wv(3'd5, 2'b11, 16'h000A, 16'h0);
    tbl[23] = rv(3'd1, 16'h000A, 16'h0000);
    tbl[24] = rv(3'd4, 16'h0004, 16'h000A);
    tbl[25] = rv(3'd4, 16'h0008, 16'h000A);
    tbl[26] = rv(3'd4, 16'h0000, 16'h0008);
    tbl[27] = mk(1'b0, 1'b0, 14'h0, 2'b00, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0000);
    tbl[28] = wv(3'd5, 2'b11, 16'h0011, 16'h0000);
    tbl[29] = rv(3'd1, 16'h0011, 16'h0000);
    tbl[30] = wv(3'd1, 2'b11, 16'h0010, 16'h0001);
    tbl[31] = rv(3'd1, 16'h0001, 16'h0001);
    tbl[32] = wv(3'd1, 2'b11, 16'h0000, 16'h0001);
    tbl[33] = rv(3'd1, 16'h0001, 16'h0001);
    tbl[34] = rv(3'd4, 16'h0002, 16'h0001);
    tbl[35] = rv(3'd1, 16'h0000, 16'h0001);
    tbl[36] = wv(3'd2, 2'b11, 16'h0000, 16'h0000);
    tbl[37] = wv(3'd5, 2'b11, 16'h0001, 16'h0000);
    tbl[38] = rv(3'd1, 16'h0000, 16'h0000);

    @(posedge mclk);
    #1;
    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].addr, tbl[i].we, tbl[i].din);
      if (tbl[i].chk_d) check($sformatf("row%0d dout", i), s_dout, tbl[i].exp_d);
      if (tbl[i].chk_i) begin
        check($sformatf("row%0d irq_out", i), s_irq, tbl[i].exp_i);
        check($sformatf("row%0d irq_any", i), 16'(s_any), 16'(|tbl[i].exp_i));
      end
    end

    // Edge mode: one-cycle pulse on source 0, then accept.
    do_reset();
    wr(3'd0, 16'h0001);
    wr(3'd2, 16'h0001);
    for (int k = 0; k <= LAT + 2; k++) begin
      irq_src = (k == 0) ? 16'h0001 : 16'h0000;
      rd(3'd1);
      check($sformatf("edge k%0d ifg", k), s_dout, (k >= LAT) ? 16'h0001 : 16'h0000);
      check($sformatf("edge k%0d irq", k), s_irq, (k >= LAT + 1) ? 16'h0001 : 16'h0000);
    end
    irq_acc = 16'h0001;
    rd(3'd1);
    check("acc ifg before", s_dout, 16'h0001);
    irq_acc = 16'h0000;
    rd(3'd1);
    check("acc ifg after", s_dout, 16'h0000);
    check("acc irq lag", s_irq, 16'h0001);
    idle();
    check("acc irq cleared", s_irq, 16'h0000);
    check("acc any cleared", 16'(s_any), 16'h0000);

    // Collision: the internal edge coincides with an IFG write-1; set must win.
    wr(3'd5, 16'h0001);
    rd(3'd1);
    check("coll pre ifg", s_dout, 16'h0001);
    irq_src = 16'h0001;
    for (int j = 0; j < LAT - 1; j++) idle();
    wr(3'd1, 16'h0001);
    rd(3'd1);
    check("coll set wins", s_dout, 16'h0001);
    wr(3'd1, 16'h0001);
    rd(3'd1);
    check("coll later clear", s_dout, 16'h0000);
    irq_src = 16'h0000;

    // Level mode with active-low polarity on source 2.
    wr(3'd2, 16'h0000);
    wr(3'd3, 16'h0004);
    wr(3'd0, 16'h0004);
    irq_acc = 16'h0004;
    idle();
    irq_acc = 16'h0000;
    idle();
    rd(3'd1);
    check("level ifg", s_dout, 16'h0004);
    check("level irq", s_irq, 16'h0004);
    check("level any", 16'(s_any), 16'h0001);
    wr(3'd1, 16'h0004);
    idle();
    rd(3'd1);
    check("level w1c ignored", s_dout, 16'h0004);
    irq_src = 16'h0004;
    for (int k = 0; k <= LAT + 2; k++) begin
      rd(3'd1);
      check($sformatf("level k%0d ifg", k), s_dout, (k < LAT) ? 16'h0004 : 16'h0000);
      check($sformatf("level k%0d irq", k), s_irq, (k < LAT + 1) ? 16'h0004 : 16'h0000);
    end
    irq_src = 16'h0000;

    // Polarity flip in edge mode raises no flag; a falling edge then does.
    do_reset();
    wr(3'd0, 16'h0002);
    wr(3'd2, 16'h0002);
    wr(3'd3, 16'h0002);
    for (int j = 0; j < LAT + 2; j++) idle();
    rd(3'd1);
    check("pol no spurious", s_dout, 16'h0000);
    irq_src = 16'h0002;
    for (int j = 0; j < LAT + 2; j++) idle();
    rd(3'd1);
    check("pol rising ignored", s_dout, 16'h0000);
    irq_src = 16'h0000;
    for (int k = 0; k <= LAT; k++) begin
      rd(3'd1);
      check($sformatf("fall k%0d ifg", k), s_dout, (k >= LAT) ? 16'h0002 : 16'h0000);
    end
    idle();
    check("fall irq", s_irq, 16'h0002);

    // Reset during a write discards it and drops pending requests.
    cyc(1'b1, 1'b1, BASE, 2'b11, 16'hFFFF);
    rd(3'd0);
    check("rst wr ie", s_dout, 16'h0000);
    check("rst irq", s_irq, 16'h0000);
    check("rst any", 16'(s_any), 16'h0000);
    rd(3'd1);
    check("rst ifg", s_dout, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
